mdu_div_iter: RTL
=================

Name: mdu_div_iter

Overview:
- Iterative 32-bit divider for the DIV/DIVU instructions, directly downstream of Regfiles.
- Consumes the two register read ports (rs to dividend, rt to divisor) and produces quotient/remainder for the HI/LO registers.
- Restoring algorithm, one quotient bit per clock.
- The control unit stalls the PC while busy is high.

Parameters:
WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request pulse; sampled only when busy=0
is_signed  input  1  1=DIV (two's complement), 0=DIVU; captured with start
dividend  input  WIDTH  rs value from Regfiles rdata1; captured with start
divisor  input  WIDTH  rt value from Regfiles rdata2; captured with start
quotient  output  WIDTH  result quotient, to LO
remainder  output  WIDTH  result remainder, to HI
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when quotient/remainder become valid

Behaviour:
- Reset (rst=1 at a rising edge): quotient=0, remainder=0, busy=0, done=0, FSM to IDLE. Applies mid-operation too; the operation in flight is aborted and no done is produced.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start=1 captures the operands.
  - In signed mode, stores absolute values and records the quotient sign (sign(a) xor sign(b)) and the remainder sign (sign(a)).
  - Clears the partial remainder and the iteration counter, then moves to RUN with busy=1 from the next cycle.
- RUN, each cycle:
  - partial remainder = {partial remainder, next dividend MSB}.
  - Trial subtract of |divisor|, width WIDTH+1 so the borrow is visible.
  - Non-negative result: keep the difference, shift in quotient bit 1. Negative result: restore, shift in 0.
  - Counter increments; after WIDTH iterations go to FIX.
- FIX:
  - Applies the sign corrections (two's-complement negate) and registers quotient/remainder.
  - Asserts done for exactly one cycle, busy=0 in that same cycle, then returns to IDLE.
- Latency: start sampled at edge 0 gives done=1 in the cycle after edge WIDTH+1, i.e. 33 cycles for WIDTH=32. The latency is fixed and data-independent.
- start while busy=1 is ignored; the operands are not recaptured.
- start in the same cycle done=1 is accepted (busy is already low); back-to-back operations are legal.
- quotient/remainder hold their values until the next FIX or reset. They are not valid during RUN and may show stale values.
- Signed semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives quotient 0x80000000, remainder 0 (wrap, no trap).
- Divide by zero without the feature:
  - The algorithm runs normally: unsigned gives quotient all-ones and remainder = dividend.
  - Signed gives the same magnitudes with the sign rules applied.
- Operand inputs may change freely after the start cycle.

Optional Feature:
- Macro MDU_DIV_ZERO_DETECT_EN.
- Defined:
  - Adds output div_zero (1 bit, reset 0).
  - divisor=0 at start skips RUN: FIX is entered on the next edge, so done arrives 2 cycles after start.
  - quotient=all-ones, remainder=dividend (raw captured value, no sign fix).
  - div_zero=1 in the done cycle only.
- Not defined: no div_zero port; divide by zero takes the full latency with the results given under Behaviour.

Decomposition:
- Shared CPU package holds the FSM state encoding (IDLE/RUN/FIX) and the WIDTH default constant.
- One natural sub-module: div_step (combinational trial-subtract/shift slice producing the next partial remainder and quotient bit). Everything else stays in the top.

Test Plan:
- DIVU 100/7, start one cycle → done exactly 33 cycles later; quotient=14, remainder=2; busy high for cycles 1–32 plus the FIX cycle.
- DIV 0xFFFFFFF9 (-7) / 2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); DIV 7 / -2 → quotient=0xFFFFFFFD, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0; DIVU same operands → quotient=0, remainder=0x80000000.
- Divide by zero, DIVU 0x1234/0:
  - Without the macro: 33-cycle latency, quotient=0xFFFFFFFF, remainder=0x1234.
  - With MDU_DIV_ZERO_DETECT_EN: done after 2 cycles with div_zero=1 and the same results.
- Robustness: start re-pulsed with new operands at cycle 10 of an operation → ignored, original result delivered. Start asserted in the done cycle → second result valid 33 cycles later.
- rst=1 at cycle 15 of an operation → next cycle busy=0, done=0, quotient=remainder=0; no done pulse follows.

Source files
------------

// File: rtl/mdu_div_iter_pkg.sv
// Shared definitions for the iterative divider: default operand width and
// the FSM state encoding used by mdu_div_iter.
package mdu_div_iter_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/mdu_div_iter_if.sv
// Request/result bundle between the control unit / register file and the
// iterative divider. The master drives the request, the slave (the divider)
// drives the results. Build option MDU_DIV_ZERO_DETECT_EN adds div_zero.
import mdu_div_iter_pkg::*;

interface mdu_div_iter_if #(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
`ifdef MDU_DIV_ZERO_DETECT_EN
  logic             div_zero;
`endif

  modport master (
    output start, is_signed, dividend, divisor,
`ifdef MDU_DIV_ZERO_DETECT_EN
    input  div_zero,
`endif
    input  quotient, remainder, busy, done
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
`ifdef MDU_DIV_ZERO_DETECT_EN
    output div_zero,
`endif
    output quotient, remainder, busy, done
  );
endinterface

// File: rtl/mdu_div_iter_div_step.sv
// One restoring-division slice: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor magnitude and either keep the
// difference (quotient bit 1) or restore the shifted value (quotient bit 0).
module mdu_div_iter_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  // One extra bit so the borrow of the trial subtract shows up in the MSB.
  // The partial remainder is always below the divisor, so the shifted value
  // is below twice the divisor and the MSB is a reliable sign.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {1'b0, dvsr};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/mdu_div_iter.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock,
// WIDTH iterations, then a single fix-up cycle that applies the signs and
// registers the results. Fixed latency, data independent.
// Build option MDU_DIV_ZERO_DETECT_EN: a zero divisor skips the iterations
// and flags div_zero in the done cycle.
module mdu_div_iter
  import mdu_div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  mdu_div_iter_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_reg, state_next;
  logic [WIDTH-1:0] rem_reg;       // partial remainder
  logic [WIDTH-1:0] dvd_reg;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvsr_reg;      // divisor magnitude
  logic             q_neg_reg;
  logic             r_neg_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             done_reg;
`ifdef MDU_DIV_ZERO_DETECT_EN
  logic             dz_reg;        // captured divisor was zero
  logic [WIDTH-1:0] raw_dvd_reg;   // dividend as presented, for the zero case
  logic             div_zero_reg;
`endif

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic             last_iter;
  logic             a_neg;
  logic             b_neg;

  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
  assign a_neg     = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg     = bus.is_signed & bus.divisor[WIDTH-1];

  mdu_div_iter_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .bit_in  (dvd_reg[WIDTH-1]),
    .dvsr    (dvsr_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: IDLE waits for start, RUN iterates, FIX lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = ST_RUN;
      ST_RUN: begin
        if (last_iter) state_next = ST_FIX;
`ifdef MDU_DIV_ZERO_DETECT_EN
        if (dz_reg) state_next = ST_FIX;
`endif
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, per-cycle iteration and result fix-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg       <= '0;
      dvd_reg       <= '0;
      dvsr_reg      <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      done_reg      <= 1'b0;
`ifdef MDU_DIV_ZERO_DETECT_EN
      dz_reg        <= 1'b0;
      raw_dvd_reg   <= '0;
      div_zero_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= (state_reg == ST_FIX);
`ifdef MDU_DIV_ZERO_DETECT_EN
      div_zero_reg <= (state_reg == ST_FIX) && dz_reg;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            dvd_reg   <= a_neg ? -bus.dividend : bus.dividend;
            dvsr_reg  <= b_neg ? -bus.divisor  : bus.divisor;
            q_neg_reg <= a_neg ^ b_neg;
            r_neg_reg <= a_neg;
            rem_reg   <= '0;
            cnt_reg   <= '0;
`ifdef MDU_DIV_ZERO_DETECT_EN
            dz_reg      <= (bus.divisor == '0);
            raw_dvd_reg <= bus.dividend;
`endif
          end
        end
        ST_RUN: begin
          rem_reg <= step_rem;
          dvd_reg <= {dvd_reg[WIDTH-2:0], step_q};
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        ST_FIX: begin
          quotient_reg  <= q_neg_reg ? -dvd_reg : dvd_reg;
          remainder_reg <= r_neg_reg ? -rem_reg : rem_reg;
`ifdef MDU_DIV_ZERO_DETECT_EN
          if (dz_reg) begin
            quotient_reg  <= '1;
            remainder_reg <= raw_dvd_reg;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = done_reg;
`ifdef MDU_DIV_ZERO_DETECT_EN
  assign bus.div_zero  = div_zero_reg;
`endif
endmodule
